// File: rtl/timing_gen_if.sv
// Timing generator bundle: the hold request plus every phase/strobe/subcycle
// output. The generator drives through the slave modport; whatever consumes
// the timing (core logic or bench) uses the master modport.
interface timing_gen_if;
  logic       hold;
  logic       clk1_en;
  logic       clk2_en;
  logic       clk1;
  logic       clk2;
  logic [2:0] phase;
  logic       a1, a2, a3, m1, m2, x1, x2, x3;
  logic       sync;

  modport master (
    output hold,
    input  clk1_en, clk2_en, clk1, clk2, phase,
    input  a1, a2, a3, m1, m2, x1, x2, x3, sync
  );

  modport slave (
    input  hold,
    output clk1_en, clk2_en, clk1, clk2, phase,
    output a1, a2, a3, m1, m2, x1, x2, x3, sync
  );
endinterface

// File: rtl/timing_gen.sv
// MCS-4 two-phase clock and instruction-cycle timing generator.
//
// phase | meaning
// A1..A3| address nibbles out (0..2)
// M1,M2 | opcode fetch (3,4)
// X1..X3| execute (5..7); X3 carries SYNC, and the generator parks here on hold
//
// Each subcycle is 4 slots (clk1, gap, clk2, gap) of DIV sysclk cycles each.
// Outputs are registered from the next-state values so they line up with the
// state that the same edge loads.
module timing_gen #(
  parameter int DIV = 2
) (
  input logic          sysclk,
  input logic          poc,
  timing_gen_if.slave  bus
);

  localparam int            W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  DIV_LAST = W'(DIV - 1);

  typedef enum logic [2:0] {
    A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
    M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
  } phase_t;

  logic [W-1:0] div_cnt, div_nxt;
  logic [1:0]   slot, slot_nxt;
  phase_t       ph, ph_nxt;
  logic [7:0]   dec;

  // Next-count logic; hold only matters on the edge that would leave X3 for A1.
  always_comb begin
    div_nxt  = div_cnt;
    slot_nxt = slot;
    ph_nxt   = ph;
    if (!(ph == X3 && slot == 2'd3 && div_cnt == DIV_LAST && bus.hold)) begin
      if (div_cnt == DIV_LAST) begin
        div_nxt  = '0;
        slot_nxt = slot + 2'd1;
        if (slot == 2'd3)
          ph_nxt = phase_t'(ph + 3'd1);
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end
  end

  // Counter state and registered outputs; poc parks everything at the end of X3.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      div_cnt     <= DIV_LAST;
      slot        <= 2'd3;
      ph          <= X3;
      bus.clk1    <= 1'b0;
      bus.clk2    <= 1'b0;
      bus.clk1_en <= 1'b0;
      bus.clk2_en <= 1'b0;
      bus.phase   <= X3;
      bus.sync    <= 1'b1;
      dec         <= 8'b1000_0000;
    end else begin
      div_cnt     <= div_nxt;
      slot        <= slot_nxt;
      ph          <= ph_nxt;
      bus.clk1    <= (slot_nxt == 2'd0);
      bus.clk2    <= (slot_nxt == 2'd2);
      bus.clk1_en <= (slot_nxt == 2'd0) && (div_nxt == '0);
      bus.clk2_en <= (slot_nxt == 2'd2) && (div_nxt == '0);
      bus.phase   <= ph_nxt;
      bus.sync    <= (ph_nxt == X3);
      dec         <= 8'b1 << ph_nxt;
    end
  end

  // One-hot subcycle decode, straight from its register.
  assign bus.a1 = dec[0];
  assign bus.a2 = dec[1];
  assign bus.a3 = dec[2];
  assign bus.m1 = dec[3];
  assign bus.m2 = dec[4];
  assign bus.x1 = dec[5];
  assign bus.x2 = dec[6];
  assign bus.x3 = dec[7];

endmodule

// File: tb/tb_timing_gen.sv
// Bench for timing_gen: DIV=2 instance for reset/waveform/full-cycle/hold/
// mid-op reset, DIV=1 instance driving a master/slave counter model.
module tb_timing_gen;

  logic sysclk = 1'b0;
  logic poc2   = 1'b1;
  logic poc1   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 sysclk = ~sysclk;

  timing_gen_if if2 ();
  timing_gen_if if1 ();

  timing_gen #(.DIV(2)) dut2 (.sysclk(sysclk), .poc(poc2), .bus(if2.slave));
  timing_gen #(.DIV(1)) dut1 (.sysclk(sysclk), .poc(poc1), .bus(if1.slave));

  // Downstream master/slave counter: step_a loads ~q into master, step_b moves it to q.
  logic cnt_m, cnt_q;
  always @(posedge sysclk) begin
    if (poc1) begin
      cnt_m <= 1'b0;
      cnt_q <= 1'b0;
    end else begin
      if (if1.clk1_en) cnt_m <= ~cnt_q;
      if (if1.clk2_en) cnt_q <= cnt_m;
    end
  end

  typedef struct {
    logic       poc;
    logic       hold;
    logic       clk1;
    logic       clk2;
    logic       c1en;
    logic       c2en;
    logic [2:0] ph;
    logic       sync;
  } vec_t;

  vec_t vt [21];

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic c1, input logic c2,
                      input logic e1, input logic e2, input logic [2:0] ph,
                      input logic s);
    logic [7:0] oh;
    logic [7:0] act_oh;
    oh     = 8'b1 << ph;
    act_oh = {if2.x3, if2.x2, if2.x1, if2.m2, if2.m1, if2.a3, if2.a2, if2.a1};
    chk({tag, " clk1"},    int'(if2.clk1),    int'(c1));
    chk({tag, " clk2"},    int'(if2.clk2),    int'(c2));
    chk({tag, " clk1_en"}, int'(if2.clk1_en), int'(e1));
    chk({tag, " clk2_en"}, int'(if2.clk2_en), int'(e2));
    chk({tag, " phase"},   int'(if2.phase),   int'(ph));
    chk({tag, " sync"},    int'(if2.sync),    int'(s));
    chk({tag, " onehot"},  int'(act_oh),      int'(oh));
  endtask

  // Closed-form expectation for cycle c after edge 0 with divider d.
  task automatic chk_model(input string tag, input int c, input int d);
    int ph, sl, dv;
    ph = (c / (4 * d)) % 8;
    sl = (c / d) % 4;
    dv = c % d;
    chk2($sformatf("%s c%0d", tag, c), sl == 0, sl == 2,
         (sl == 0) && (dv == 0), (sl == 2) && (dv == 0), 3'(ph), ph == 7);
  endtask

  initial begin
    int toggles;
    logic q_prev;
    if2.hold = 1'b0;
    if1.hold = 1'b0;

    // Reset for 5 cycles, then the 16-cycle DIV=2 phase waveform.
    for (int i = 0; i < 5; i++) vt[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
    vt[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
    vt[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    vt[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};

    for (int i = 0; i < 21; i++) begin
      poc2     = vt[i].poc;
      if2.hold = vt[i].hold;
      step();
      chk2($sformatf("vec%0d", i), vt[i].clk1, vt[i].clk2, vt[i].c1en,
           vt[i].c2en, vt[i].ph, vt[i].sync);
      chk($sformatf("vec%0d overlap", i), int'(if2.clk1 & if2.clk2), 0);
    end

    // Remainder of the first two instruction cycles (sync on 56-63, 120-127).
    for (int c = 16; c < 128; c++) begin
      step();
      chk_model("full", c, 2);
      chk($sformatf("full c%0d overlap", c), int'(if2.clk1 & if2.clk2), 0);
    end

    // Hold raised in A2 is ignored until the cycle finishes X3.
    for (int c = 128; c < 192; c++) begin
      if (c == 138) if2.hold = 1'b1;
      step();
      chk_model("hold_run", c - 128, 2);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      chk2($sformatf("frozen%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1);
    end
    if2.hold = 1'b0;
    step();
    chk2("hold_release", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

    // Run into M1 until clk2 is high, then pulse poc for one cycle.
    for (int o = 1; o <= 28; o++) begin
      step();
      chk_model("pre_rst", o, 2);
    end
    chk("m1 clk2 high", int'(if2.clk2), 1);
    poc2 = 1'b1;
    step();
    chk2("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1);
    poc2 = 1'b0;
    step();
    chk2("restart", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int o = 1; o < 12; o++) begin
      step();
      chk_model("post_rst", o, 2);
    end

    // DIV=1 with the downstream counter: q toggles every 4 cycles, 8 times in 32.
    poc1 = 1'b0;
    step();
    chk("div1 e0 clk1",    int'(if1.clk1),    1);
    chk("div1 e0 clk1_en", int'(if1.clk1_en), 1);
    chk("div1 e0 phase",   int'(if1.phase),   0);
    toggles = 0;
    q_prev  = cnt_q;
    for (int c = 1; c <= 32; c++) begin
      step();
      chk($sformatf("div1 c%0d en1=lvl", c), int'(if1.clk1_en), int'(if1.clk1));
      chk($sformatf("div1 c%0d en2=lvl", c), int'(if1.clk2_en), int'(if1.clk2));
      chk($sformatf("div1 c%0d clk2", c), int'(if1.clk2), int'((c % 4) == 2));
      chk($sformatf("div1 c%0d phase", c), int'(if1.phase), (c / 4) % 8);
      chk($sformatf("div1 c%0d q toggle", c), int'(cnt_q != q_prev), int'((c % 4) == 3));
      if (cnt_q != q_prev) toggles++;
      q_prev = cnt_q;
    end
    chk("div1 toggle count", toggles, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
